// File: rtl/toggle_cover_pkg.sv
// Shared constants and helpers for the toggle-coverage producer path.
package toggle_cover_pkg;

    localparam int COVER_INDEX_W = 64;

    // Absolute cover index of a bit's rise (is_fall=0) or fall (is_fall=1) point.
    function automatic logic [COVER_INDEX_W-1:0] point_index(
        input logic [COVER_INDEX_W-1:0] base,
        input int unsigned              bit_idx,
        input logic                     is_fall
    );
        return base + COVER_INDEX_W'(2 * bit_idx) + COVER_INDEX_W'(is_fall);
    endfunction

endpackage

// File: rtl/toggle_cover_reporter_arbiter.sv
// cover_pending_arbiter: lowest-set-bit priority encoder over the pending bitmap.
module cover_pending_arbiter #(
    parameter int N     = 58,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     grant
);

    assign any   = |req;
    assign grant = req & (~req + N'(1));

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/toggle_cover_reporter.sv
// Detects per-bit rise/fall toggles, records first hits, and streams each newly
// covered point once as an absolute cover index over valid/ready.
module toggle_cover_reporter
    import toggle_cover_pkg::*;
#(
    parameter int                       WIDTH       = 29,
    parameter logic [COVER_INDEX_W-1:0] COVER_INDEX = '0,
    parameter int                       COVER_TOTAL = 8940
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               sig,
    input  logic                           cov_en,
    input  logic                           cov_clear,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [COVER_INDEX_W-1:0]       out_index,
    output logic [$clog2(2*WIDTH+1)-1:0]   covered_count,
    output logic                           all_covered
);

    localparam int NP    = 2 * WIDTH;
    localparam int CNT_W = $clog2(NP + 1);
    localparam int IDX_W = $clog2(NP);

    if (COVER_INDEX + NP > COVER_TOTAL) begin : g_range_chk
        $error("toggle_cover_reporter: points exceed COVER_TOTAL");
    end

    logic [WIDTH-1:0]         prev_q, prev_d;
    logic                     armed_q, armed_d;
    logic [NP-1:0]            covered_q, covered_d;
    logic [NP-1:0]            pending_q, pending_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     out_valid_q, out_valid_d;
    logic [COVER_INDEX_W-1:0] out_index_q, out_index_d;

    logic [NP-1:0]    hit, new_pts, take;
    logic             arb_any, load;
    logic [IDX_W-1:0] arb_idx;
    logic [NP-1:0]    arb_grant;

    function automatic logic [CNT_W-1:0] popcount(input logic [NP-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NP; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    cover_pending_arbiter #(.N(NP), .IDX_W(IDX_W)) u_arb (
        .req   (pending_q),
        .any   (arb_any),
        .idx   (arb_idx),
        .grant (arb_grant)
    );

    // Even point = rise, odd point = fall of the same bit.
    always_comb begin
        hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit[2*i]   = sig[i] & ~prev_q[i];
            hit[2*i+1] = ~sig[i] & prev_q[i];
        end
        if (!(armed_q && cov_en)) hit = '0;
        new_pts = hit & ~covered_q;
    end

    // The output register draws from pending as it stood before this edge.
    always_comb begin
        load        = ~out_valid_q | out_ready;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        take        = '0;
        if (load) begin
            out_valid_d = arb_any;
            if (arb_any) begin
                out_index_d = point_index(COVER_INDEX, 32'(arb_idx >> 1), arb_idx[0]);
                take        = arb_grant;
            end
        end
    end

    always_comb begin
        prev_d    = sig;
        armed_d   = 1'b1;
        covered_d = covered_q | new_pts;
        pending_d = (pending_q & ~take) | new_pts;
        count_d   = count_q + popcount(new_pts);
        if (cov_clear) begin
            covered_d = '0;
            pending_d = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_q      <= '0;
            armed_q     <= 1'b0;
            covered_q   <= '0;
            pending_q   <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
        end else begin
            prev_q      <= prev_d;
            armed_q     <= armed_d;
            covered_q   <= covered_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_index     = out_index_q;
    assign covered_count = count_q;
    assign all_covered   = (count_q == CNT_W'(NP));

endmodule

// File: tb/tb_toggle_cover_reporter.sv
// Scoreboard bench for toggle_cover_reporter: an array-based model predicts the
// event stream; a negedge monitor compares every presented event and status output.
module tb_toggle_cover_reporter;

    localparam int      W    = 29;
    localparam int      NP   = 2 * W;
    localparam longint  BASE = 100;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  sig;
    logic          cov_en, cov_clear, out_ready;
    logic          out_valid, all_covered;
    logic [63:0]   out_index;
    logic [5:0]    covered_count;

    toggle_cover_reporter #(.WIDTH(W), .COVER_INDEX(64'd100), .COVER_TOTAL(8940)) dut (
        .clock         (clock),
        .reset         (reset),
        .sig           (sig),
        .cov_en        (cov_en),
        .cov_clear     (cov_clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .covered_count (covered_count),
        .all_covered   (all_covered)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: sets of covered and pending points, and the order events leave.
    bit        m_cov [NP];
    bit        m_pend[NP];
    int        m_count;
    bit        m_valid;
    bit [W-1:0] m_prev;
    bit        m_armed;
    longint    exp_q[$];
    longint    got_q[$];

    always @(posedge clock) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin m_cov[p] = 0; m_pend[p] = 0; end
            m_count = 0; m_valid = 0; m_prev = '0; m_armed = 0;
            exp_q.delete();
        end else begin
            if (!m_valid || out_ready) begin
                int pick;
                pick = -1;
                for (int p = 0; p < NP; p++) if (m_pend[p] && pick < 0) pick = p;
                if (pick >= 0) begin
                    m_pend[pick] = 0;
                    m_valid = 1;
                    exp_q.push_back(BASE + pick);
                end else begin
                    m_valid = 0;
                end
            end
            if (cov_clear) begin
                for (int p = 0; p < NP; p++) begin m_cov[p] = 0; m_pend[p] = 0; end
                m_count = 0;
            end else if (m_armed && cov_en) begin
                for (int b = 0; b < W; b++) begin
                    int p;
                    p = -1;
                    if (sig[b] && !m_prev[b]) p = 2 * b;
                    if (!sig[b] && m_prev[b]) p = 2 * b + 1;
                    if (p >= 0 && !m_cov[p]) begin
                        m_cov[p] = 1; m_pend[p] = 1; m_count++;
                    end
                end
            end
            m_prev  = sig;
            m_armed = 1;
        end
    end

    bit          hold_prev = 0;
    logic [63:0] idx_prev;

    always @(negedge clock) begin
        chk("valid", longint'(out_valid), longint'(m_valid));
        chk("count", longint'(covered_count), longint'(m_count));
        chk("all_covered", longint'(all_covered), longint'(m_count == NP));
        if (hold_prev) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_index", longint'(out_index), longint'(idx_prev));
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", longint'(out_index), -1);
            end else begin
                chk("index", longint'(out_index), exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    got_q.push_back(longint'(out_index));
                end
            end
        end
        hold_prev = reset && out_valid && !out_ready;
        idx_prev  = out_index;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset(input logic [W-1:0] v);
        reset = 1'b0; sig = v; cov_en = 1'b1; cov_clear = 1'b0; out_ready = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(1);
    endtask

    function automatic int occurrences(input longint v, input int from);
        int n;
        n = 0;
        for (int i = from; i < got_q.size(); i++) if (got_q[i] == v) n++;
        return n;
    endfunction

    initial begin
        int n0, n1;
        int ord[W];

        reset = 1'b0; sig = '0; cov_en = 1'b1; cov_clear = 1'b0; out_ready = 1'b1;

        // Arming: the first sample after reset never counts as a toggle.
        do_reset('1);
        n0 = got_q.size();
        sig = '0;
        sig = '1;
        cyc(6);
        chk("arm_events", got_q.size() - n0, 0);
        chk("arm_count", longint'(covered_count), 0);

        // Single rise and two-cycle latency.
        do_reset('0);
        cyc(2);
        sig[0] = 1'b1;
        cyc(1);
        chk("lat_early_valid", longint'(out_valid), 0);
        cyc(1);
        chk("lat_valid", longint'(out_valid), 1);
        chk("lat_index", longint'(out_index), 100);
        chk("lat_count", longint'(covered_count), 1);
        cyc(2);

        sig[3] = 1'b1; cyc(4);
        sig[3] = 1'b0; cyc(4);
        chk("fall_b3", got_q[$], 107);
        sig[0] = 1'b0; cyc(4);
        sig[0] = 1'b1; cyc(4);
        n0 = got_q.size();
        sig[0] = 1'b0; cyc(2);
        sig[0] = 1'b1; cyc(4);
        chk("retoggle_events", got_q.size() - n0, 0);
        chk("rise_b0_once", occurrences(100, 0), 1);

        // Backpressure on a two-point simultaneous hit.
        out_ready = 1'b0;
        sig[2] = 1'b1; sig[5] = 1'b1;
        cyc(2);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", longint'(out_valid), 1);
            chk("bp_index", longint'(out_index), 104);
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("bp_first", got_q[$], 104);
        chk("bp_next_index", longint'(out_index), 110);
        cyc(1);
        chk("bp_second", got_q[$], 110);
        chk("bp_drained", longint'(out_valid), 0);

        // Full coverage in random bit order with random backpressure.
        do_reset('0);
        cyc(1);
        n0 = got_q.size();
        for (int i = 0; i < W; i++) ord[i] = i;
        for (int i = W - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < W; i++) begin
            sig[ord[i]] = 1'b1; out_ready = 1'($urandom_range(0, 1)); cyc(1);
        end
        for (int i = 0; i < W; i++) begin
            sig[ord[W-1-i]] = 1'b0; out_ready = 1'($urandom_range(0, 1)); cyc(1);
        end
        out_ready = 1'b1;
        cyc(70);
        chk("full_events", got_q.size() - n0, NP);
        for (int p = 0; p < NP; p++) chk($sformatf("full_once_%0d", BASE + p), occurrences(BASE + p, n0), 1);
        chk("full_count", longint'(covered_count), NP);
        chk("full_all_covered", longint'(all_covered), 1);

        // Clear beats a same-cycle hit; disabled detection records nothing.
        do_reset('0);
        cyc(2);
        n0 = got_q.size();
        sig[7] = 1'b1; cov_clear = 1'b1;
        cyc(1);
        cov_clear = 1'b0;
        cyc(4);
        chk("clr_count", longint'(covered_count), 0);
        chk("clr_no_114", occurrences(114, n0), 0);
        cov_en = 1'b0; sig[7] = 1'b0; cyc(2);
        cov_en = 1'b1; sig[7] = 1'b1; cyc(4);
        chk("clr_later_114", occurrences(114, n0), 1);
        chk("clr_later_count", longint'(covered_count), 1);
        cov_en = 1'b0;
        n1 = got_q.size();
        for (int k = 0; k < 20; k++) begin sig = W'($urandom); cyc(1); end
        cyc(4);
        chk("dis_events", got_q.size() - n1, 0);
        chk("dis_count", longint'(covered_count), 1);

        // Random soak against the model.
        do_reset('0);
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) == 0) sig = sig ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 15) == 0) sig = W'($urandom);
            cov_en    = ($urandom_range(0, 7) != 0);
            cov_clear = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc(1);
        end
        cov_clear = 1'b0; out_ready = 1'b1;
        cyc(70);
        chk("soak_drained", longint'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_cover_reporter.md
# toggle_cover_reporter

Producer side of the toggle-coverage path. It watches a WIDTH-bit signal vector and detects rising and falling transitions on each bit. It records first hits in a sticky covered bitmap. Each newly covered point is emitted once, as an absolute cover index on a valid/ready stream. A host-side sink (a DPI bridge or a coverage FIFO) consumes the stream, so coverage is deduplicated in hardware instead of the sink being called on every cycle.

## Interface
Parameters:
- WIDTH, 29, number of watched bits; cover points = 2*WIDTH
- COVER_INDEX, 0, absolute index of point 0
- COVER_TOTAL, 8940, design-wide point count; informational only

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- sig  in  WIDTH  watched vector, sampled every cycle
- cov_en  in  1  detection enable; when 0, no new hits are recorded
- cov_clear  in  1  one-cycle pulse; clears covered/pending/count
- out_valid  out  1  cover event available
- out_ready  in  1  sink accepts the event
- out_index  out  64  absolute cover index of the event
- covered_count  out  $clog2(2*WIDTH+1)  number of distinct points hit
- all_covered  out  1  covered_count == 2*WIDTH

## Operation
- Point numbering: bit i rise (0→1) = point 2i; bit i fall (1→0) = point 2i+1; out_index = COVER_INDEX + point.
- prev register samples sig every cycle. armed flag: cleared by reset, set after the first post-reset sample. No detection while armed=0.
- hit = armed & cov_en & {fall, rise} per bit, where rise = sig & ~prev and fall = ~sig & prev.
- new = hit & ~covered. At the edge: covered |= new, pending |= new, covered_count += popcount(new).
- Output register: loads when out_valid=0 or (out_valid & out_ready).
  - Source is the lowest-numbered pending bit, taken from pending as it stood before this edge.
  - On load, that pending bit clears and out_valid is set.
  - If nothing is pending, out_valid drops.
- Handshake: while out_valid & ~out_ready, out_index and out_valid hold stable. Transfer occurs on out_valid & out_ready.
- cov_clear:
  - Zeroes covered, pending and covered_count.
  - Hits in the same cycle are discarded (clear wins).
  - An in-flight out_valid is not dropped; it completes normally.
  - armed and prev are unaffected.
- Reset: out_valid=0, out_index=0, covered_count=0, all_covered=0, armed=0, prev=0, covered=pending=0.
- Reset mid-transfer: the event is lost; this is acceptable.

## Timing
- sig changes before edge k (prev holds the old value) → pending set at edge k → out_valid=1 after edge k+1. Latency is 2 cycles with the output idle.
- Back-to-back: with out_ready held high, one event per cycle, in ascending point order.
- Simultaneous hits on N new points → N events on N consecutive accepting cycles.
- A repeat hit on an already covered point never produces an event, including while its first event is still pending or held on the output.
- covered_count and all_covered update at the same edge the covered bits set. all_covered is combinational from the count.

## Structure
- Package toggle_cover_pkg: COVER_INDEX_W = 64 and function point_index(base, bit, is_fall).
- Sub-module cover_pending_arbiter:
  - Parameterised lowest-set-bit priority encoder over 2*WIDTH bits.
  - Outputs: any, idx, and a one-hot grant used to clear the pending bit.
- Top-level contents: detection, bitmaps, popcount adder, output register and handshake.

## Test plan
All scenarios use WIDTH=29 and COVER_INDEX=100.
- Arming: reset with sig=all ones, then release → no events, covered_count=0.
- Single rise: sig=0 for 2 cycles, then bit0→1 → out_valid rises 2 cycles later with out_index=100; covered_count=1.
- Fall on bit 3 (1→0) → out_index=107; toggling bit0 again → no new event.
- Backpressure: out_ready=0 while bits 2 and 5 rise together → out_index=104 held stable for 5 cycles. Raise out_ready → 104 transfers, then 110 the next cycle, then out_valid=0.
- Full coverage: walk every bit up then down → 58 events (100..157, each exactly once), covered_count=58, all_covered=1.
- Clear and enable:
  - cov_clear in the same cycle as a bit 7 rise → covered_count=0, no 114 event.
  - A later bit 7 rise → event 114.
  - With cov_en=0, toggling any bit yields no events.
